decode_stage: RTL and testbench

- RV32I decode stage directly downstream of the fetch stage; consumes fetch's pc, instr_send and clk_en.
- Extracts register addresses, builds the sign-extended immediate and classifies the opcode.
- Detects load-use hazards against the execute stage, then registers everything into the decode/execute pipeline register.
- Participates in the shared stall/flush/clk_en bubble scheme.

---
 rtl/decode_stage.sv | 203 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: field extraction, immediate build, opcode classification,
// load-use hazard detection and the decode/execute pipeline register. Macro RV32M_EN adds M-extension ops.
module decode_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_ce,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic [4:0]  o_rs1_q,
  output logic [4:0]  o_rs2_q,
  output logic [31:0] o_imm,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic [10:0] o_op,
  output logic        o_illegal,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_ce,
`ifdef RV32M_EN
  output logic        o_muldiv,
`endif
  input  logic        i_ex_load,
  input  logic        i_ex_ce,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic        o_stall
);

  logic [6:0]  opcode_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [10:0] op_s;
  logic [31:0] imm_s;
  logic        illegal_s;
  logic        uses_rs1_s;
  logic        uses_rs2_s;
  logic        hazard_s;
  logic        load_s;
`ifdef RV32M_EN
  logic        muldiv_s;
  logic        muldiv_r;
`endif

  logic        ce_r;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] imm_r;
  logic [10:0] op_r;
  logic        illegal_r;

  assign opcode_s   = i_instr[6:0];
  assign f3_s       = i_instr[14:12];
  assign f7_s       = i_instr[31:25];
  assign o_rs1_addr = i_instr[19:15];
  assign o_rs2_addr = i_instr[24:20];

  // Opcode classification; bit order {fence,system,op,op_imm,store,load,branch,jalr,jal,auipc,lui}
  always_comb begin
    op_s = 11'h000;
    case (opcode_s)
      7'b0110111: op_s = 11'h001;
      7'b0010111: op_s = 11'h002;
      7'b1101111: op_s = 11'h004;
      7'b1100111: op_s = 11'h008;
      7'b1100011: op_s = 11'h010;
      7'b0000011: op_s = 11'h020;
      7'b0100011: op_s = 11'h040;
      7'b0010011: op_s = 11'h080;
      7'b0110011: op_s = 11'h100;
      7'b1110011: op_s = 11'h200;
      7'b0001111: op_s = 11'h400;
      default:    op_s = 11'h000;
    endcase
  end

  // Sign-extended immediate selected by instruction format
  always_comb begin
    imm_s = 32'h0000_0000;
    if (op_s[0] || op_s[1]) begin
      imm_s = {i_instr[31:12], 12'h000};
    end else if (op_s[2]) begin
      imm_s = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
    end else if (op_s[4]) begin
      imm_s = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    end else if (op_s[6]) begin
      imm_s = {{21{i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
    end else if (op_s[3] || op_s[5] || op_s[7] || op_s[9]) begin
      imm_s = {{21{i_instr[31]}}, i_instr[30:20]};
    end else begin
      imm_s = 32'h0000_0000;
    end
  end

  // Illegal encodings within recognised classes; unrecognised opcodes are always illegal
  always_comb begin
    illegal_s = 1'b0;
`ifdef RV32M_EN
    muldiv_s  = 1'b0;
`endif
    if (op_s == 11'h000) begin
      illegal_s = 1'b1;
    end else if (op_s[3]) begin
      illegal_s = (f3_s != 3'b000);
    end else if (op_s[4]) begin
      illegal_s = (f3_s == 3'b010) || (f3_s == 3'b011);
    end else if (op_s[5]) begin
      illegal_s = (f3_s == 3'b011) || (f3_s[2:1] == 2'b11);
    end else if (op_s[6]) begin
      illegal_s = (f3_s >= 3'b011);
    end else if (op_s[7]) begin
      if (f3_s == 3'b001) begin
        illegal_s = (f7_s != 7'h00);
      end else if (f3_s == 3'b101) begin
        illegal_s = (f7_s != 7'h00) && (f7_s != 7'h20);
      end else begin
        illegal_s = 1'b0;
      end
    end else if (op_s[8]) begin
      if (f7_s == 7'h00) begin
        illegal_s = 1'b0;
      end else if (f7_s == 7'h20) begin
        illegal_s = (f3_s != 3'b000) && (f3_s != 3'b101);
`ifdef RV32M_EN
      end else if (f7_s == 7'h01) begin
        illegal_s = 1'b0;
        muldiv_s  = 1'b1;
`endif
      end else begin
        illegal_s = 1'b1;
      end
    end else begin
      illegal_s = 1'b0;
    end
  end

  assign uses_rs1_s = op_s[3] | op_s[4] | op_s[5] | op_s[6] | op_s[7] | op_s[8];
  assign uses_rs2_s = op_s[4] | op_s[6] | op_s[8];
  assign hazard_s   = i_ce & i_ex_ce & i_ex_load & (i_ex_rd != 5'd0) &
                      ((uses_rs1_s & (i_instr[19:15] == i_ex_rd)) |
                       (uses_rs2_s & (i_instr[24:20] == i_ex_rd)));
  assign o_stall    = i_stall | hazard_s;
  assign load_s     = ~i_flush & ~i_stall & ~hazard_s & i_ce;

  // Valid bit: flush beats stall, stall beats hazard bubble
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ce_r <= 1'b0;
    end else if (i_flush) begin
      ce_r <= 1'b0;
    end else if (i_stall) begin
      ce_r <= ce_r;
    end else if (hazard_s) begin
      ce_r <= 1'b0;
    end else begin
      ce_r <= i_ce;
    end
  end

  // Data registers capture only on an accepted valid instruction
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_r      <= PC_RESET;
      instr_r   <= 32'h0000_0000;
      imm_r     <= 32'h0000_0000;
      op_r      <= 11'h000;
      illegal_r <= 1'b0;
`ifdef RV32M_EN
      muldiv_r  <= 1'b0;
`endif
    end else if (load_s) begin
      pc_r      <= i_pc;
      instr_r   <= i_instr;
      imm_r     <= imm_s;
      op_r      <= op_s;
      illegal_r <= illegal_s;
`ifdef RV32M_EN
      muldiv_r  <= muldiv_s;
`endif
    end
  end

  assign o_ce      = ce_r;
  assign o_pc      = pc_r;
  assign o_instr   = instr_r;
  assign o_imm     = imm_r;
  assign o_op      = op_r;
  assign o_illegal = illegal_r;
  assign o_rd_addr = instr_r[11:7];
  assign o_rs1_q   = instr_r[19:15];
  assign o_rs2_q   = instr_r[24:20];
  assign o_funct3  = instr_r[14:12];
  assign o_funct7  = instr_r[31:25];
`ifdef RV32M_EN
  assign o_muldiv  = muldiv_r;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage: expectations queued at drive time, popped one cycle later.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] i_pc = 32'h0;
  logic [31:0] i_instr = 32'h0;
  logic        i_ce = 1'b0;
  logic        i_ex_load = 1'b0;
  logic        i_ex_ce = 1'b0;
  logic [4:0]  i_ex_rd = 5'd0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr, o_rs1_q, o_rs2_q;
  logic [31:0] o_imm, o_pc, o_instr;
  logic [2:0]  o_funct3;
  logic [6:0]  o_funct7;
  logic [10:0] o_op;
  logic        o_illegal, o_ce, o_stall;
`ifdef RV32M_EN
  logic        o_muldiv;
`endif

  decode_stage #(.PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn), .i_pc(i_pc), .i_instr(i_instr), .i_ce(i_ce),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
    .o_rs1_q(o_rs1_q), .o_rs2_q(o_rs2_q), .o_imm(o_imm), .o_funct3(o_funct3),
    .o_funct7(o_funct7), .o_op(o_op), .o_illegal(o_illegal), .o_pc(o_pc),
    .o_instr(o_instr), .o_ce(o_ce),
`ifdef RV32M_EN
    .o_muldiv(o_muldiv),
`endif
    .i_ex_load(i_ex_load), .i_ex_ce(i_ex_ce), .i_ex_rd(i_ex_rd),
    .i_stall(i_stall), .i_flush(i_flush), .o_stall(o_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic [10:0] op;
    logic [31:0] imm;
    logic        ill;
    logic        md;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sbq[$];
  exp_t cur_e;
  exp_t rst_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    logic [31:0] ins;
    ins = e.instr;
    chk("o_ce", {31'd0, o_ce}, {31'd0, e.ce});
    chk("o_op", {21'd0, o_op}, {21'd0, e.op});
    chk("o_imm", o_imm, e.imm);
    chk("o_illegal", {31'd0, o_illegal}, {31'd0, e.ill});
    chk("o_pc", o_pc, e.pc);
    chk("o_instr", o_instr, e.instr);
    chk("o_rd_addr", {27'd0, o_rd_addr}, {27'd0, ins[11:7]});
    chk("o_rs1_q", {27'd0, o_rs1_q}, {27'd0, ins[19:15]});
    chk("o_rs2_q", {27'd0, o_rs2_q}, {27'd0, ins[24:20]});
    chk("o_funct3", {29'd0, o_funct3}, {29'd0, ins[14:12]});
    chk("o_funct7", {25'd0, o_funct7}, {25'd0, ins[31:25]});
`ifdef RV32M_EN
    chk("o_muldiv", {31'd0, o_muldiv}, {31'd0, e.md});
`endif
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic ce);
    i_pc = pc;
    i_instr = instr;
    i_ce = ce;
  endtask

  // Expect the currently driven instruction to be captured with these decode results
  task automatic exp_ld(input logic [10:0] op, input logic [31:0] imm, input logic ill, input logic md);
    exp_t e;
    e.ce = 1'b1; e.op = op; e.imm = imm; e.ill = ill; e.md = md;
    e.pc = i_pc; e.instr = i_instr;
    cur_e = e;
    sbq.push_back(e);
  endtask

  // Expect data registers to hold, with the given valid bit
  task automatic exp_hold(input logic ce);
    exp_t e;
    e = cur_e;
    e.ce = ce;
    cur_e = e;
    sbq.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sbq.pop_front();
      compare(e);
    end
  endtask

  initial begin
    rst_e.ce = 1'b0; rst_e.op = 11'h000; rst_e.imm = 32'h0; rst_e.ill = 1'b0;
    rst_e.md = 1'b0; rst_e.pc = 32'h0; rst_e.instr = 32'h0;
    cur_e = rst_e;
    #12;
    compare(rst_e);
    rstn = 1'b1;
    @(posedge clk); #1;

    drive(32'h100, 32'h0050_0093, 1'b1); exp_ld(11'h080, 32'h0000_0005, 1'b0, 1'b0); step();
    drive(32'h104, 32'hFE20_8EE3, 1'b1); exp_ld(11'h010, 32'hFFFF_FFFC, 1'b0, 1'b0); step();
    drive(32'h108, 32'h0020_A423, 1'b1); exp_ld(11'h040, 32'h0000_0008, 1'b0, 1'b0); step();
    drive(32'h10C, 32'h0020_B423, 1'b1); exp_ld(11'h040, 32'h0000_0008, 1'b1, 1'b0); step();
    drive(32'h110, 32'h0000_90E7, 1'b1); exp_ld(11'h008, 32'h0000_0000, 1'b1, 1'b0); step();
    drive(32'h114, 32'h4010_9093, 1'b1); exp_ld(11'h080, 32'h0000_0401, 1'b1, 1'b0); step();
    drive(32'h118, 32'h4010_5093, 1'b1); exp_ld(11'h080, 32'h0000_0401, 1'b0, 1'b0); step();
    drive(32'h11C, 32'h4020_81B3, 1'b1); exp_ld(11'h100, 32'h0000_0000, 1'b0, 1'b0); step();
    drive(32'h120, 32'h4020_91B3, 1'b1); exp_ld(11'h100, 32'h0000_0000, 1'b1, 1'b0); step();
    drive(32'h124, 32'h0100_00EF, 1'b1); exp_ld(11'h004, 32'h0000_0010, 1'b0, 1'b0); step();
    drive(32'h128, 32'hFFFF_F297, 1'b1); exp_ld(11'h002, 32'hFFFF_F000, 1'b0, 1'b0); step();
    drive(32'h12C, 32'h3000_1073, 1'b1); exp_ld(11'h200, 32'h0000_0300, 1'b0, 1'b0); step();
    drive(32'h130, 32'h0000_0000, 1'b1); exp_ld(11'h000, 32'h0000_0000, 1'b1, 1'b0); step();
`ifdef RV32M_EN
    drive(32'h134, 32'h0220_81B3, 1'b1); exp_ld(11'h100, 32'h0000_0000, 1'b0, 1'b1); step();
`else
    drive(32'h134, 32'h0220_81B3, 1'b1); exp_ld(11'h100, 32'h0000_0000, 1'b1, 1'b0); step();
`endif
    // Invalid input: bubble, data hold
    drive(32'h138, 32'h0050_0093, 1'b0); exp_hold(1'b0); step();

    // Load-use hazard on rs1, then execute retires the load
    drive(32'h200, 32'h0012_8333, 1'b1);
    i_ex_load = 1'b1; i_ex_ce = 1'b1; i_ex_rd = 5'd5;
    #1;
    chk("hazard_stall", {31'd0, o_stall}, 32'd1);
    chk("rs1_addr", {27'd0, o_rs1_addr}, 32'd5);
    chk("rs2_addr", {27'd0, o_rs2_addr}, 32'd1);
    exp_hold(1'b0); step();
    i_ex_ce = 1'b0;
    #1;
    chk("retired_stall", {31'd0, o_stall}, 32'd0);
    exp_ld(11'h100, 32'h0000_0000, 1'b0, 1'b0); step();
    // Load into x0 never stalls
    drive(32'h204, 32'h0012_8333, 1'b1);
    i_ex_ce = 1'b1; i_ex_rd = 5'd0;
    #1;
    chk("x0_stall", {31'd0, o_stall}, 32'd0);
    exp_ld(11'h100, 32'h0000_0000, 1'b0, 1'b0); step();
    i_ex_load = 1'b0; i_ex_ce = 1'b0;

    // Downstream stall freezes everything for three cycles, then flush bubbles
    drive(32'h300, 32'h1234_53B7, 1'b1); exp_ld(11'h001, 32'h1234_5000, 1'b0, 1'b0); step();
    drive(32'h304, 32'h0050_0093, 1'b1);
    i_stall = 1'b1;
    #1;
    chk("down_stall", {31'd0, o_stall}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      exp_hold(1'b1); step();
    end
    i_flush = 1'b1;
    exp_hold(1'b0); step();
    i_flush = 1'b0; i_stall = 1'b0;

    // Asynchronous reset while valid
    drive(32'h400, 32'h0050_0093, 1'b1); exp_ld(11'h080, 32'h0000_0005, 1'b0, 1'b0); step();
    rstn = 1'b0;
    #1;
    cur_e = rst_e;
    compare(rst_e);
    #2;
    rstn = 1'b1;
    drive(32'h404, 32'hFE20_8EE3, 1'b1); exp_ld(11'h010, 32'hFFFF_FFFC, 1'b0, 1'b0); step();
    drive(32'h408, 32'h0000_0000, 1'b0); exp_hold(1'b0); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
